// File: rtl/fifo_stream_packer_pkg.sv
// fifo_stream_packer_pkg: shared helpers and configuration checks for the stream packer
package fifo_stream_packer_pkg;

   function automatic int cnt_bits(input int ratio);
      return (ratio <= 1) ? 1 : $clog2(ratio);
   endfunction

   function automatic bit cfg_ok(input int ratio, input int cnt_width);
      return (ratio >= 1) && (cnt_width == cnt_bits(ratio));
   endfunction

   function automatic bit lane_filled(input int lane, input int cnt);
      return lane < cnt;
   endfunction

endpackage

// File: rtl/fifo_stream_packer_slot.sv
// fifo_stream_packer_slot: one-entry output register with load/drain handshake
module fifo_stream_packer_slot
   import fifo_stream_packer_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   // load wins over drain, so a same-cycle drain and reload leaves no bubble
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         valid <= 1'b0;
         data  <= '0;
      end else begin
         valid <= load | (valid & ~ready);
         if (load) data <= load_data;
      end

endmodule

// File: rtl/fifo_stream_packer.sv
// fifo_stream_packer: packs RATIO narrow FWFT words into one wide word; optional flush via FIFO_STREAM_PACKER_FLUSH_EN
module fifo_stream_packer
   import fifo_stream_packer_pkg::*;
#(
   parameter int IN_WIDTH  = 32,
   parameter int RATIO     = 4,
   parameter int CNT_WIDTH = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      s_empty_n,
   input  logic [IN_WIDTH-1:0]       s_dout,
   output logic                      s_read,
   output logic                      s_read_ce,
   input  logic                      m_full_n,
   output logic                      m_write,
   output logic                      m_write_ce,
   output logic [IN_WIDTH*RATIO-1:0] m_din
`ifdef FIFO_STREAM_PACKER_FLUSH_EN
   ,
   input  logic                      flush
`endif
);

   localparam int OUT_WIDTH = IN_WIDTH * RATIO;
   localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(RATIO - 1);

   if (!cfg_ok(RATIO, CNT_WIDTH)) begin : g_cfg_err
      $error("fifo_stream_packer: RATIO must be >=1 and CNT_WIDTH must equal max(1,clog2(RATIO))");
   end

   logic [CNT_WIDTH-1:0] cnt;
   logic [OUT_WIDTH-1:0] acc;
   logic [OUT_WIDTH-1:0] word;
   logic                 out_valid;
   logic                 drain;
   logic                 pop;
   logic                 complete;
   logic                 flush_go;
   logic                 load;

   assign s_read_ce  = 1'b1;
   assign m_write_ce = 1'b1;
   assign m_write    = out_valid;

   // handshake: only the final lane waits for the output slot; nothing moves in reset
   always_comb begin
      drain    = out_valid & m_full_n;
      s_read   = reset & s_empty_n & ((cnt != LAST) | ~out_valid | drain);
      pop      = s_read;
      complete = pop & (cnt == LAST);
`ifdef FIFO_STREAM_PACKER_FLUSH_EN
      flush_go = flush & ~complete & ((cnt != '0) | pop) & (~out_valid | drain);
`else
      flush_go = 1'b0;
`endif
      load     = complete | flush_go;
   end

   // wide word: filled lanes from acc, current lane from the head word, unfilled lanes zero
   always_comb begin
      word = '0;
      for (int k = 0; k < RATIO; k++)
         word[k*IN_WIDTH +: IN_WIDTH] = (pop && CNT_WIDTH'(k) == cnt) ? s_dout :
                                        lane_filled(k, int'(cnt)) ? acc[k*IN_WIDTH +: IN_WIDTH] : '0;
   end

   // lane counter and accumulator; lanes are overwritten before reuse, so no clear on wrap
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         cnt <= '0;
         acc <= '0;
      end else begin
         cnt <= load ? '0 : pop ? cnt + CNT_WIDTH'(1) : cnt;
         for (int k = 0; k < RATIO; k++)
            if (pop && CNT_WIDTH'(k) == cnt) acc[k*IN_WIDTH +: IN_WIDTH] <= s_dout;
      end

   fifo_stream_packer_slot #(.WIDTH(OUT_WIDTH)) u_slot (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .load_data (word),
      .ready     (m_full_n),
      .valid     (out_valid),
      .data      (m_din)
   );

endmodule

// File: tb/tb_fifo_stream_packer.sv
// tb_fifo_stream_packer: directed checks of the RATIO=4 packer plus a RATIO=1 ordering run
module tb_fifo_stream_packer;

   logic        clk = 1'b0;
   logic        reset;
   logic        e4, f4, r4, w4, rce4, wce4;
   logic [7:0]  d4;
   logic [31:0] din4;
   logic        e1, f1, r1, w1, rce1, wce1;
   logic [7:0]  d1, din1;
`ifdef FIFO_STREAM_PACKER_FLUSH_EN
   logic        fl4, fl1;
`endif
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fifo_stream_packer #(.IN_WIDTH(8), .RATIO(4), .CNT_WIDTH(2)) u4 (
      .clk(clk), .reset(reset), .s_empty_n(e4), .s_dout(d4), .s_read(r4), .s_read_ce(rce4),
      .m_full_n(f4), .m_write(w4), .m_write_ce(wce4), .m_din(din4)
`ifdef FIFO_STREAM_PACKER_FLUSH_EN
      , .flush(fl4)
`endif
   );

   fifo_stream_packer #(.IN_WIDTH(8), .RATIO(1), .CNT_WIDTH(1)) u1 (
      .clk(clk), .reset(reset), .s_empty_n(e1), .s_dout(d1), .s_read(r1), .s_read_ce(rce1),
      .m_full_n(f1), .m_write(w1), .m_write_ce(wce1), .m_din(din1)
`ifdef FIFO_STREAM_PACKER_FLUSH_EN
      , .flush(fl1)
`endif
   );

   task automatic test_reset();
      reset = 1'b0; e4 = 1'b1; f4 = 1'b1; d4 = 8'hAB; e1 = 1'b1; f1 = 1'b1; d1 = 8'hCD;
`ifdef FIFO_STREAM_PACKER_FLUSH_EN
      fl4 = 1'b0; fl1 = 1'b0;
`endif
      #3;
      checks++; if (w4 !== 1'b0) begin errors++; $display("FAIL reset_w4: got %b want 0", w4); end
      checks++; if (r4 !== 1'b0) begin errors++; $display("FAIL reset_r4: got %b want 0", r4); end
      checks++; if (din4 !== 32'h0) begin errors++; $display("FAIL reset_din4: got %h want 0", din4); end
      checks++; if ({rce4, wce4, rce1, wce1} !== 4'hF) begin errors++; $display("FAIL reset_ce: got %b want 1111", {rce4, wce4, rce1, wce1}); end
      checks++; if ({r1, w1} !== 2'b00) begin errors++; $display("FAIL reset_u1: got %b want 00", {r1, w1}); end
      @(posedge clk); #1;
      checks++; if ({r4, w4} !== 2'b00) begin errors++; $display("FAIL reset_held: got %b want 00", {r4, w4}); end
      e4 = 1'b0; e1 = 1'b0; reset = 1'b1;
   endtask

   task automatic test_single();
      logic [31:0] pk = 32'h44332211;
      for (int i = 0; i < 6; i++) begin
         e4 = (i < 4); f4 = 1'b1; d4 = (i < 4) ? pk[8*i +: 8] : 8'h00;
         @(negedge clk);
         checks++; if (r4 !== (i < 4)) begin errors++; $display("FAIL single_rd cyc %0d: got %b want %b", i, r4, i < 4); end
         checks++; if (w4 !== (i == 4)) begin errors++; $display("FAIL single_wr cyc %0d: got %b want %b", i, w4, i == 4); end
         if (i == 4) begin
            checks++; if (din4 !== 32'h44332211) begin errors++; $display("FAIL single_din: got %h want 44332211", din4); end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_stream();
      logic [31:0] exp;
      for (int i = 0; i < 18; i++) begin
         e4 = (i < 16); f4 = 1'b1; d4 = 8'(i);
         @(negedge clk);
         if (i < 16) begin
            checks++; if (r4 !== 1'b1) begin errors++; $display("FAIL stream_rd cyc %0d: got %b want 1", i, r4); end
         end
         checks++; if (w4 !== (i >= 4 && i % 4 == 0)) begin errors++; $display("FAIL stream_wr cyc %0d: got %b want %b", i, w4, i >= 4 && i % 4 == 0); end
         if (i >= 4 && i % 4 == 0) begin
            for (int l = 0; l < 4; l++) exp[8*l +: 8] = 8'(i - 4 + l);
            checks++; if (din4 !== exp) begin errors++; $display("FAIL stream_din cyc %0d: got %h want %h", i, din4, exp); end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure();
      int idx = 0;
      for (int i = 0; i < 4; i++) begin
         e4 = 1'b1; f4 = 1'b1; d4 = 8'(8'h50 + i);
         @(negedge clk);
         checks++; if (r4 !== 1'b1) begin errors++; $display("FAIL bp_fill_rd cyc %0d: got %b want 1", i, r4); end
         @(posedge clk); #1;
      end
      for (int b = 0; b < 10; b++) begin
         e4 = 1'b1; f4 = 1'b0; d4 = 8'(8'h54 + idx);
         @(negedge clk);
         checks++; if (r4 !== (b < 3)) begin errors++; $display("FAIL bp_rd blk %0d: got %b want %b", b, r4, b < 3); end
         checks++; if (w4 !== 1'b1 || din4 !== 32'h53525150) begin errors++; $display("FAIL bp_hold blk %0d: got %b/%h want 1/53525150", b, w4, din4); end
         if (b < 3) idx++;
         @(posedge clk); #1;
      end
      e4 = 1'b1; f4 = 1'b1; d4 = 8'h57;
      @(negedge clk);
      checks++; if ({r4, w4} !== 2'b11 || din4 !== 32'h53525150) begin errors++; $display("FAIL bp_release: got %b/%h want 11/53525150", {r4, w4}, din4); end
      @(posedge clk); #1;
      e4 = 1'b0;
      @(negedge clk);
      checks++; if ({r4, w4} !== 2'b01 || din4 !== 32'h57565554) begin errors++; $display("FAIL bp_reload: got %b/%h want 01/57565554", {r4, w4}, din4); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (w4 !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", w4); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      logic [31:0] pk = 32'h74737271;
      for (int i = 0; i < 6; i++) begin
         e4 = 1'b1; f4 = (i < 4); d4 = 8'(8'h61 + i);
         @(negedge clk);
         @(posedge clk); #1;
      end
      e4 = 1'b1; f4 = 1'b0; d4 = 8'h67;
      #2 reset = 1'b0;
      #1;
      checks++; if ({r4, w4} !== 2'b00 || din4 !== 32'h0) begin errors++; $display("FAIL rstmid_async: got %b/%h want 00/00000000", {r4, w4}, din4); end
      @(posedge clk); #1;
      checks++; if ({r4, w4} !== 2'b00) begin errors++; $display("FAIL rstmid_held: got %b want 00", {r4, w4}); end
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         e4 = (i < 4); f4 = 1'b1; d4 = (i < 4) ? pk[8*i +: 8] : 8'h00;
         @(negedge clk);
         checks++; if ({r4, w4} !== {i < 4, i == 4}) begin errors++; $display("FAIL rstmid_hs cyc %0d: got %b want %b", i, {r4, w4}, {i < 4, i == 4}); end
         if (i == 4) begin
            checks++; if (din4 !== 32'h74737271) begin errors++; $display("FAIL rstmid_din: got %h want 74737271", din4); end
         end
         @(posedge clk); #1;
      end
   endtask

`ifdef FIFO_STREAM_PACKER_FLUSH_EN
   task automatic test_flush();
      logic [31:0] pk = 32'h04030201;
      for (int i = 0; i < 6; i++) begin
         e4 = (i < 2); f4 = 1'b1; d4 = (i == 0) ? 8'hAA : 8'hBB; fl4 = (i == 2 || i == 4);
         @(negedge clk);
         checks++; if (w4 !== (i == 3)) begin errors++; $display("FAIL flush_wr cyc %0d: got %b want %b", i, w4, i == 3); end
         if (i == 3) begin
            checks++; if (din4 !== 32'h0000BBAA) begin errors++; $display("FAIL flush_din: got %h want 0000bbaa", din4); end
         end
         @(posedge clk); #1;
      end
      fl4 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         e4 = (i < 4); d4 = (i < 4) ? pk[8*i +: 8] : 8'h00;
         @(negedge clk);
         checks++; if (w4 !== (i == 4)) begin errors++; $display("FAIL flush_after_wr cyc %0d: got %b want %b", i, w4, i == 4); end
         if (i == 4) begin
            checks++; if (din4 !== 32'h04030201) begin errors++; $display("FAIL flush_after_din: got %h want 04030201", din4); end
         end
         @(posedge clk); #1;
      end
   endtask
`endif

   task automatic test_ratio1();
      logic [7:0] src [1001];
      int sent = 0, recv = 0, cyc = 0;
      for (int i = 0; i < 1001; i++) src[i] = 8'($urandom);
      while (recv < 1000 && cyc < 20000) begin
         e1 = (sent < 1000) && ($urandom_range(0, 3) != 0);
         d1 = src[sent];
         f1 = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         checks++; if (r1 !== (e1 & (~w1 | f1))) begin errors++; $display("FAIL r1_read cyc %0d: got %b want %b", cyc, r1, e1 & (~w1 | f1)); end
         if (w1 && f1) begin
            checks++; if (din1 !== src[recv]) begin errors++; $display("FAIL r1_data word %0d: got %h want %h", recv, din1, src[recv]); end
            recv++;
         end
         if (r1) sent++;
         @(posedge clk); #1;
         cyc++;
      end
      e1 = 1'b0;
      checks++; if (recv != 1000) begin errors++; $display("FAIL r1_count: got %0d want 1000", recv); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_stream();
      test_backpressure();
      test_reset_mid();
`ifdef FIFO_STREAM_PACKER_FLUSH_EN
      test_flush();
`endif
      test_ratio1();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
